// File: rtl/pipeline_controller_pkg.sv
// Shared definitions for the pipeline controller.
// - pipe_ctrl_state_t : controller FSM states
// - OPC_*             : RV32 major opcodes the controller cares about
package pipeline_controller_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2,
        ST_ERROR    = 2'd3
    } pipe_ctrl_state_t;

    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

endpackage

// File: rtl/pipeline_controller_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst_n (async low), inc (count this cycle), clr (load 0,
// wins over inc), cnt (current value, sticks at all-ones).
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {WIDTH{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline hazard/flow controller for a 5-stage in-order core.
// Inputs : id_stall, ex_redirect/ex_target, halt_req, resume,
//          mem_req/mem_ready, clr_stats.
// Outputs: stage enables (if/id/ex/mem), IF/ID and ID/EX flushes,
//          pc_sel/pc_target redirect, halted, err (sticky timeout),
//          stall_cnt (cycles with the fetch stage frozen).
// All stage controls are combinational in state and inputs.
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_stall,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    input  logic        halt_req,
    input  logic        resume,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        clr_stats,
    output logic        if_en,
    output logic        id_en,
    output logic        ex_en,
    output logic        mem_en,
    output logic        if_flush,
    output logic        id_flush,
    output logic        pc_sel,
    output logic [31:0] pc_target,
    output logic        halted,
    output logic        err,
    output logic [31:0] stall_cnt
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    pipe_ctrl_state_t state, state_nx;
    logic [TW-1:0]    tmo_cnt, tmo_nx, tmo_inc;
    logic [3:0]       en;      // {if, id, ex, mem}
    logic             flush;
    logic             sel;
    logic             run_dec; // evaluate the RUN priority chain below (a)

    assign tmo_inc = tmo_cnt + 1'b1;

    always_comb begin
        state_nx = state;
        tmo_nx   = tmo_cnt;
        en       = 4'b0000;
        flush    = 1'b0;
        sel      = 1'b0;
        run_dec  = 1'b0;

        case (state)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    state_nx = ST_MEM_WAIT;
                    tmo_nx   = '0;
                end else begin
                    run_dec = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // Redirect/halt are held off until the access completes;
                // the completing cycle then behaves like a normal RUN cycle.
                if (mem_ready) begin
                    run_dec = 1'b1;
                end else begin
                    tmo_nx = tmo_inc;
                    if (tmo_inc == TW'(MEM_TIMEOUT))
                        state_nx = ST_ERROR;
                end
            end
            ST_HALT: begin
                if (resume)
                    state_nx = ST_RUN;
            end
            default: ; // ST_ERROR: only reset leaves
        endcase

        if (run_dec) begin
            state_nx = ST_RUN;
            if (halt_req) begin
                flush    = 1'b1;
                state_nx = ST_HALT;
            end else if (ex_redirect) begin
                en    = 4'b1111;
                sel   = 1'b1;
                flush = 1'b1;
            end else if (id_stall) begin
                en = 4'b0011;
            end else begin
                en = 4'b1111;
            end
        end

        // Keep the pipeline quiescent while reset is held.
        if (!rst_n) begin
            en    = 4'b0000;
            flush = 1'b0;
            sel   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nx;
            tmo_cnt <= tmo_nx;
        end
    end

    assign {if_en, id_en, ex_en, mem_en} = en;
    assign if_flush  = flush;
    assign id_flush  = flush;
    assign pc_sel    = sel;
    assign pc_target = sel ? ex_target : 32'd0;
    assign halted    = (state == ST_HALT);
    assign err       = (state == ST_ERROR);

    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!if_en),
        .clr   (clr_stats),
        .cnt   (stall_cnt)
    );

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: a table of single-cycle RUN
// decisions plus hand-written multi-cycle sequences (stall, memory wait,
// timeout/error, halt/resume, async reset). A second instance with
// MEM_TIMEOUT=4 shares the inputs and is used for the timeout sequence.
module tb_pipeline_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_stall, ex_redirect, halt_req, resume, mem_req, mem_ready, clr_stats;
    logic [31:0] ex_target;

    logic        if_en, id_en, ex_en, mem_en, if_flush, id_flush, pc_sel, halted, err;
    logic [31:0] pc_target, stall_cnt;
    logic        t_if_en, t_id_en, t_ex_en, t_mem_en, t_if_flush, t_id_flush, t_pc_sel, t_halted, t_err;
    logic [31:0] t_pc_target, t_stall_cnt;

    logic [3:0] en, t_en;
    assign en   = {if_en, id_en, ex_en, mem_en};
    assign t_en = {t_if_en, t_id_en, t_ex_en, t_mem_en};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_controller dut (
        .clk(clk), .rst_n(rst_n), .id_stall(id_stall), .ex_redirect(ex_redirect),
        .ex_target(ex_target), .halt_req(halt_req), .resume(resume), .mem_req(mem_req),
        .mem_ready(mem_ready), .clr_stats(clr_stats), .if_en(if_en), .id_en(id_en),
        .ex_en(ex_en), .mem_en(mem_en), .if_flush(if_flush), .id_flush(id_flush),
        .pc_sel(pc_sel), .pc_target(pc_target), .halted(halted), .err(err),
        .stall_cnt(stall_cnt)
    );

    pipeline_controller #(.MEM_TIMEOUT(4)) dut_t4 (
        .clk(clk), .rst_n(rst_n), .id_stall(id_stall), .ex_redirect(ex_redirect),
        .ex_target(ex_target), .halt_req(halt_req), .resume(resume), .mem_req(mem_req),
        .mem_ready(mem_ready), .clr_stats(clr_stats), .if_en(t_if_en), .id_en(t_id_en),
        .ex_en(t_ex_en), .mem_en(t_mem_en), .if_flush(t_if_flush), .id_flush(t_id_flush),
        .pc_sel(t_pc_sel), .pc_target(t_pc_target), .halted(t_halted), .err(t_err),
        .stall_cnt(t_stall_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        id_stall = 0; ex_redirect = 0; ex_target = 0; halt_req = 0;
        resume = 0; mem_req = 0; mem_ready = 0; clr_stats = 0;
    endtask

    task automatic clear_stats();
        @(negedge clk); clr_stats = 1;
        @(negedge clk); clr_stats = 0;
    endtask

    typedef struct {
        logic        stall, redir, halt, mreq, mrdy;
        logic [31:0] tgt;
        logic [3:0]  en;
        logic        flush, sel;
        logic [31:0] pct;
    } vec_t;

    vec_t vt[10];

    initial begin
        //               stall redir halt mreq mrdy tgt           en       fl  sel pct
        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        4'b1111, 1'b0, 1'b0, 32'h0};
        vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        4'b0011, 1'b0, 1'b0, 32'h0};
        vt[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40,       4'b1111, 1'b1, 1'b1, 32'h40};
        vt[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 4'b1111, 1'b1, 1'b1, 32'hDEADBEEF};
        vt[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b1, 1'b0, 32'h0};
        vt[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80,       4'b0000, 1'b1, 1'b0, 32'h0};
        vt[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h80,       4'b0000, 1'b0, 1'b0, 32'h0};
        vt[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        4'b0011, 1'b0, 1'b0, 32'h0};
        vt[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        4'b1111, 1'b0, 1'b0, 32'h0};
        vt[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h123,      4'b0011, 1'b0, 1'b0, 32'h0};

        idle();
        rst_n = 0;
        ex_redirect = 1; ex_target = 32'h55; // must be masked during reset
        #3;
        chk("rst_en", en, 4'b0000);
        chk("rst_flush", {if_flush, id_flush}, 2'b00);
        chk("rst_pc_sel", pc_sel, 1'b0);
        chk("rst_pc_target", pc_target, 32'h0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_err", err, 1'b0);
        idle();
        @(negedge clk); @(negedge clk);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        rst_n = 1;

        // Idle after reset: everything enabled, no stall cycles counted.
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("idle%0d_en", c), en, 4'b1111);
            chk($sformatf("idle%0d_cnt", c), stall_cnt, 32'd0);
            @(negedge clk);
        end

        // Single-cycle RUN decisions; inputs return to idle before the edge.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            id_stall = vt[i].stall; ex_redirect = vt[i].redir; halt_req = vt[i].halt;
            mem_req = vt[i].mreq; mem_ready = vt[i].mrdy; ex_target = vt[i].tgt;
            #1;
            chk($sformatf("vec%0d_en", i), en, vt[i].en);
            chk($sformatf("vec%0d_flush", i), {if_flush, id_flush}, {vt[i].flush, vt[i].flush});
            chk($sformatf("vec%0d_sel", i), pc_sel, vt[i].sel);
            chk($sformatf("vec%0d_pct", i), pc_target, vt[i].pct);
            #1 idle();
        end

        // Three decode stalls.
        clear_stats();
        id_stall = 1;
        for (int c = 0; c < 3; c++) begin
            #1 chk($sformatf("stall%0d_en", c), en, 4'b0011);
            @(negedge clk);
        end
        id_stall = 0;
        #1 chk("stall_cnt3", stall_cnt, 32'd3);
        chk("stall_done_en", en, 4'b1111);

        // Clear beats increment in the same cycle.
        @(negedge clk); id_stall = 1; clr_stats = 1;
        @(negedge clk); idle();
        #1 chk("clr_prio_cnt", stall_cnt, 32'd0);

        // Memory wait: 5 frozen cycles, redirect/halt ignored while waiting.
        clear_stats();
        mem_req = 1; mem_ready = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2 || c == 3) begin ex_redirect = 1; halt_req = 1; ex_target = 32'h80; end
            else begin ex_redirect = 0; halt_req = 0; ex_target = 0; end
            #1;
            chk($sformatf("mw%0d_en", c), en, 4'b0000);
            chk($sformatf("mw%0d_flush_sel", c), {if_flush, id_flush, pc_sel}, 3'b000);
            @(negedge clk);
        end
        ex_redirect = 0; halt_req = 0; ex_target = 0;
        mem_ready = 1;
        #1 chk("mw_done_en", en, 4'b1111);
        @(negedge clk); idle();
        #1;
        chk("mw_after_en", en, 4'b1111);
        chk("mw_after_err", err, 1'b0);
        chk("mw_after_halted", halted, 1'b0);
        chk("mw_stall_cnt", stall_cnt, 32'd5);

        // Timeout on the MEM_TIMEOUT=4 instance.
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        mem_req = 1; mem_ready = 0;
        #1 chk("to_run_en", t_en, 4'b0000);
        @(negedge clk);
        for (int c = 1; c <= 4; c++) begin
            #1 chk($sformatf("to_mw%0d_err", c), t_err, 1'b0);
            @(negedge clk);
        end
        #1;
        chk("to_err_set", t_err, 1'b1);
        chk("to_err_en", t_en, 4'b0000);
        mem_req = 0; mem_ready = 1; resume = 1;
        @(negedge clk); @(negedge clk);
        #1;
        chk("to_err_sticky", t_err, 1'b1);
        chk("to_err_sticky_en", t_en, 4'b0000);
        chk("main_no_err", err, 1'b0);

        // Async reset while the main instance sits in MEM_WAIT.
        idle();
        mem_req = 1; mem_ready = 0;
        @(negedge clk); @(negedge clk);
        #1 chk("pre_rst_cnt_nz", (stall_cnt != 0), 1'b1);
        #1 rst_n = 0;
        #1;
        chk("arst_cnt", stall_cnt, 32'd0);
        chk("arst_en", en, 4'b0000);
        chk("arst_t_err", t_err, 1'b0);
        idle();
        @(negedge clk); rst_n = 1;
        #1;
        chk("arst_rel_en", en, 4'b1111);
        chk("arst_rel_t_en", t_en, 4'b1111);
        chk("arst_rel_t_err", t_err, 1'b0);

        // Halt for 6 cycles, resume on the 6th.
        clear_stats();
        halt_req = 1;
        #1;
        chk("halt_req_en", en, 4'b0000);
        chk("halt_req_flush", {if_flush, id_flush}, 2'b11);
        chk("halt_req_halted", halted, 1'b0);
        @(negedge clk); halt_req = 0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 6) resume = 1;
            #1;
            chk($sformatf("halt%0d_halted", c), halted, 1'b1);
            chk($sformatf("halt%0d_en", c), en, 4'b0000);
            @(negedge clk);
        end
        resume = 0;
        #1;
        chk("resumed_halted", halted, 1'b0);
        chk("resumed_en", en, 4'b1111);
        chk("halt_stall_cnt", stall_cnt, 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
